bky_capture_fsm: RTL and testbench

Serial readback engine for the Buckeye shift chain; it is the return path for the Buckeye load sequencer. When START is asserted, it shifts NWORDS serial words of WORD_BITS bits out of the chain, assembles each word MSB-first, and writes it to the readback FIFO with write-side back-pressure. It then raises SET_DONE and holds it until START is released. It sits between the Buckeye chain serial output and the readback FIFO write port.

---
 rtl/bky_capture_fsm.sv | 155 +++++++++++++++
 tb/tb_bky_capture_fsm.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bky_capture_fsm.sv
// bky_capture_fsm: readback engine for the Buckeye shift chain.
// Shifts NWORDS serial words of WORD_BITS bits out of the chain, assembles each
// word MSB-first and writes it to the readback FIFO, honouring FIFO back-pressure.
// Build option: define BKY_CHKSUM_EN to append an XOR checksum word after the
// last data word. Without it the final write goes straight to Set_Done.
// All state, including the synchronous active-high RST, updates on the falling CLK edge.
module bky_capture_fsm (
    input  logic        CLK,
    input  logic        RST,
    input  logic        START,
    input  logic        SDI,
    input  logic        FULL,
    output logic        SHFT_ENA,
    output logic        WRENA,
    output logic [15:0] DOUT,
    output logic        SET_DONE,
    output logic        BUSY
);

    localparam int unsigned WORD_BITS  = 16;
    localparam int unsigned NWORDS     = 19;
    localparam int unsigned BIT_CNT_W  = 4;
    localparam int unsigned WORD_CNT_W = 5;

    localparam logic [BIT_CNT_W-1:0]  BIT_LAST  = BIT_CNT_W'(WORD_BITS - 1);
    localparam logic [WORD_CNT_W-1:0] WORD_LAST = WORD_CNT_W'(NWORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SHIFT  = 3'd1,
        S_WAIT   = 3'd2,
        S_WRITE  = 3'd3,
        S_DONE   = 3'd4,
        S_CHKSUM = 3'd5
    } state_t;

    state_t                state;
    state_t                nextstate;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic [BIT_CNT_W-1:0]  bit_cnt_nxt;
    logic [WORD_CNT_W-1:0] word_cnt;
    logic [WORD_CNT_W-1:0] word_cnt_nxt;
    logic [WORD_BITS-1:0]  dout_nxt;

`ifdef BKY_CHKSUM_EN
    logic [WORD_BITS-1:0]  acc;
    logic [WORD_BITS-1:0]  acc_nxt;
    logic                  chk_pend;
    logic                  chk_pend_nxt;
`endif

    // Next-state and datapath update for the capture sequence
    always_comb begin
        nextstate    = state;
        bit_cnt_nxt  = bit_cnt;
        word_cnt_nxt = word_cnt;
        dout_nxt     = DOUT;
`ifdef BKY_CHKSUM_EN
        acc_nxt      = acc;
        chk_pend_nxt = chk_pend;
`endif
        case (state)
            S_IDLE: begin
                if (START) begin
                    nextstate    = S_SHIFT;
                    bit_cnt_nxt  = '0;
                    word_cnt_nxt = '0;
                    dout_nxt     = '0;
`ifdef BKY_CHKSUM_EN
                    acc_nxt      = '0;
                    chk_pend_nxt = 1'b0;
`endif
                end
            end
            S_SHIFT: begin
                dout_nxt    = {DOUT[WORD_BITS-2:0], SDI};
                bit_cnt_nxt = bit_cnt + BIT_CNT_W'(1);
                if (bit_cnt == BIT_LAST) begin
                    nextstate = FULL ? S_WAIT : S_WRITE;
                end
            end
            S_WAIT: begin
                if (!FULL) begin
`ifdef BKY_CHKSUM_EN
                    nextstate = chk_pend ? S_CHKSUM : S_WRITE;
`else
                    nextstate = S_WRITE;
`endif
                end
            end
            S_WRITE: begin
                // FULL was clear on entry, so this write is committed regardless of FULL now
                word_cnt_nxt = word_cnt + WORD_CNT_W'(1);
`ifdef BKY_CHKSUM_EN
                acc_nxt = acc ^ DOUT;
`endif
                if (word_cnt == WORD_LAST) begin
`ifdef BKY_CHKSUM_EN
                    // Checksum word is loaded now so DOUT holds it through any FULL stall
                    dout_nxt     = acc ^ DOUT;
                    chk_pend_nxt = 1'b1;
                    nextstate    = FULL ? S_WAIT : S_CHKSUM;
`else
                    nextstate = S_DONE;
`endif
                end else begin
                    nextstate = S_SHIFT;
                end
            end
            S_CHKSUM: begin
                nextstate = S_DONE;
            end
            S_DONE: begin
                if (!START) begin
                    nextstate = S_IDLE;
                end
            end
            default: begin
                nextstate = S_IDLE;
            end
        endcase
    end

    // State, counters and outputs; outputs decoded from nextstate so they track the state held
    always_ff @(negedge CLK) begin
        if (RST) begin
            state    <= S_IDLE;
            bit_cnt  <= '0;
            word_cnt <= '0;
            DOUT     <= '0;
            SHFT_ENA <= 1'b0;
            WRENA    <= 1'b0;
            SET_DONE <= 1'b0;
            BUSY     <= 1'b0;
`ifdef BKY_CHKSUM_EN
            acc      <= '0;
            chk_pend <= 1'b0;
`endif
        end else begin
            state    <= nextstate;
            bit_cnt  <= bit_cnt_nxt;
            word_cnt <= word_cnt_nxt;
            DOUT     <= dout_nxt;
            SHFT_ENA <= (nextstate == S_SHIFT);
            WRENA    <= (nextstate == S_WRITE) || (nextstate == S_CHKSUM);
            SET_DONE <= (nextstate == S_DONE);
            BUSY     <= (nextstate != S_IDLE);
`ifdef BKY_CHKSUM_EN
            acc      <= acc_nxt;
            chk_pend <= chk_pend_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_bky_capture_fsm.sv
// tb_bky_capture_fsm: self-checking bench for bky_capture_fsm.
// Each scenario is built as a per-edge timeline (inputs sampled at the falling
// edge, outputs expected after it) from the word/stall/reset description, then
// played back; a compare process checks the DUT on every rising edge.
module tb_bky_capture_fsm;

    localparam int NW = 19;
`ifdef BKY_CHKSUM_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    // Output pattern {shft, wr, done, busy}
    localparam logic [3:0] O_ZERO  = 4'b0000;
    localparam logic [3:0] O_SHIFT = 4'b1001;
    localparam logic [3:0] O_WAIT  = 4'b0001;
    localparam logic [3:0] O_WRITE = 4'b0101;
    localparam logic [3:0] O_DONE  = 4'b0011;

    typedef struct {
        logic        rst;
        logic        start;
        logic        sdi;
        logic        full;
        logic        mark;
        logic        chk;
        logic        dchk;
        logic [3:0]  o;
        logic [15:0] dout;
    } rec_t;

    logic        CLK;
    logic        RST;
    logic        START;
    logic        SDI;
    logic        FULL;
    logic        SHFT_ENA;
    logic        WRENA;
    logic [15:0] DOUT;
    logic        SET_DONE;
    logic        BUSY;

    rec_t        q[$];
    rec_t        cur;
    int          cur_idx;
    int          edge_no;
    int          k_edge;
    int          n_pass;
    int          n_total;
    int          wr_idx[$];
    logic [15:0] wr_val[$];
    int          done_idx[$];
    logic        prev_done;
    logic [15:0] wv [NW];

    bky_capture_fsm dut (
        .CLK      (CLK),
        .RST      (RST),
        .START    (START),
        .SDI      (SDI),
        .FULL     (FULL),
        .SHFT_ENA (SHFT_ENA),
        .WRENA    (WRENA),
        .DOUT     (DOUT),
        .SET_DONE (SET_DONE),
        .BUSY     (BUSY)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h required %0h (edge %0d)", nm, act, exp, cur_idx);
    endtask

    // Compare process: outputs settle after the falling edge, sampled on the rising edge
    initial begin
        prev_done = 1'b0;
        forever begin
            @(posedge CLK);
            if (cur.chk) begin
                check("SHFT_ENA", 32'(SHFT_ENA), 32'(cur.o[3]));
                check("WRENA",    32'(WRENA),    32'(cur.o[2]));
                check("SET_DONE", 32'(SET_DONE), 32'(cur.o[1]));
                check("BUSY",     32'(BUSY),     32'(cur.o[0]));
                if (cur.dchk) check("DOUT", 32'(DOUT), 32'(cur.dout));
                if (WRENA === 1'b1) begin
                    wr_idx.push_back(cur_idx);
                    wr_val.push_back(DOUT);
                end
                if (SET_DONE === 1'b1 && !prev_done) done_idx.push_back(cur_idx);
                prev_done = (SET_DONE === 1'b1);
            end
        end
    end

    task automatic push(input logic rst, input logic start, input logic sdi, input logic full,
                        input logic [3:0] o, input logic dchk, input logic [15:0] dout);
        rec_t r;
        r.rst = rst; r.start = start; r.sdi = sdi; r.full = full;
        r.mark = 1'b0; r.chk = 1'b1; r.dchk = dchk; r.o = o; r.dout = dout;
        q.push_back(r);
    endtask

    task automatic add_idle(input int n, input logic dchk);
        for (int i = 0; i < n; i++) push(1'b0, 1'b0, 1'b0, 1'b0, O_ZERO, dchk, 16'h0000);
    endtask

    // Timeline of one capture: 16 shift edges + 1 write edge per word, plus FULL stalls
    task automatic add_capture(input int st_word, input int st_len,
                               input int rst_word, input int rst_bit, input int hold);
        logic [15:0] x;
        int s;
        x = 16'h0000;
        push(1'b0, 1'b1, 1'b0, 1'b0, O_SHIFT, 1'b1, 16'h0000);
        q[q.size()-1].mark = 1'b1;
        for (int n = 0; n < NW; n++) begin
            for (int b = 15; b >= 0; b--) begin
                if (n == rst_word && b == rst_bit) begin
                    push(1'b1, 1'b0, wv[n][b], 1'b0, O_ZERO, 1'b1, 16'h0000);
                    add_idle(3, 1'b1);
                    return;
                end
                if (b > 0) begin
                    push(1'b0, 1'b0, wv[n][b], 1'b0, O_SHIFT, 1'b0, 16'h0000);
                end else begin
                    s = (n == st_word) ? st_len : 0;
                    push(1'b0, 1'b0, wv[n][b], s > 0, (s > 0) ? O_WAIT : O_WRITE, 1'b1, wv[n]);
                    for (int i = 1; i <= s; i++)
                        push(1'b0, 1'b0, 1'b0, i < s, (i < s) ? O_WAIT : O_WRITE, 1'b1, wv[n]);
                end
            end
            x = x ^ wv[n];
            if (n < NW - 1) begin
                // FULL raised in the write cycle itself must not cancel the write
                push(1'b0, 1'b0, 1'b0, 1'b1, O_SHIFT, 1'b0, 16'h0000);
            end else if (CHK == 1) begin
                push(1'b0, 1'b0, 1'b0, 1'b0, O_WRITE, 1'b1, x);
                push(1'b0, 1'b0, 1'b0, 1'b0, O_DONE, 1'b0, 16'h0000);
            end else begin
                push(1'b0, 1'b0, 1'b0, 1'b0, O_DONE, 1'b0, 16'h0000);
            end
        end
        for (int i = 0; i < hold; i++) push(1'b0, 1'b1, 1'b0, 1'b0, O_DONE, 1'b0, 16'h0000);
        push(1'b0, 1'b0, 1'b0, 1'b0, O_ZERO, 1'b0, 16'h0000);
        add_idle(3, 1'b0);
    endtask

    task automatic play();
        wr_idx.delete();
        wr_val.delete();
        done_idx.delete();
        foreach (q[i]) begin
            @(posedge CLK);
            #1;
            RST   = q[i].rst;
            START = q[i].start;
            SDI   = q[i].sdi;
            FULL  = q[i].full;
            edge_no++;
            if (q[i].mark) k_edge = edge_no;
            cur_idx = edge_no;
            cur     = q[i];
        end
        @(posedge CLK);
        #1;
        cur.chk = 1'b0;
        START   = 1'b0;
        FULL    = 1'b0;
        q.delete();
    endtask

    function automatic logic [15:0] gen_word(input int i);
        if (i == 0) return 16'hA5C3;
        if (i == 1) return 16'h0001;
        return 16'((i * 32'h1357) ^ 32'h00F0);
    endfunction

    initial begin
        n_pass = 0; n_total = 0; edge_no = 0; k_edge = 0; cur_idx = 0;
        cur.chk = 1'b0;
        RST = 1'b1; START = 1'b0; SDI = 1'b0; FULL = 1'b0;
        for (int i = 0; i < NW; i++) wv[i] = gen_word(i);

        // Reset for two edges, then idle with START low
        push(1'b1, 1'b0, 1'b0, 1'b0, O_ZERO, 1'b1, 16'h0000);
        push(1'b1, 1'b0, 1'b0, 1'b0, O_ZERO, 1'b1, 16'h0000);
        add_idle(4, 1'b1);
        play();

        // Full capture, START held 10 cycles past done
        add_capture(-1, 0, -1, -1, 10);
        play();
        check("nwrites",    32'(wr_idx.size()), 32'(NW + CHK));
        check("w0_edge",    32'(wr_idx[0] - k_edge), 32'd16);
        check("w1_edge",    32'(wr_idx[1] - k_edge), 32'd33);
        check("w18_edge",   32'(wr_idx[18] - k_edge), 32'd322);
        check("w0_data",    32'(wr_val[0]), 32'h0000A5C3);
        check("w1_data",    32'(wr_val[1]), 32'h00000001);
        check("done_edge",  32'(done_idx[0] - k_edge), 32'(323 + CHK));
        check("done_once",  32'(done_idx.size()), 32'd1);

        // FULL high 5 cycles from word 3's last-bit edge
        add_capture(3, 5, -1, -1, 0);
        play();
        check("stall_w2_edge", 32'(wr_idx[2] - k_edge), 32'd50);
        check("stall_w3_edge", 32'(wr_idx[3] - k_edge), 32'd72);
        check("stall_w3_data", 32'(wr_val[3]), 32'(wv[3]));
        check("stall_done",    32'(done_idx[0] - k_edge), 32'(328 + CHK));

        // Reset during word 7 bit 9, then a clean restart
        add_capture(-1, 0, 7, 9, 0);
        play();
        check("rst_nwrites", 32'(wr_idx.size()), 32'd7);
        check("rst_nodone",  32'(done_idx.size()), 32'd0);
        add_capture(-1, 0, -1, -1, 2);
        play();
        check("restart_w0",  32'(wr_val[0]), 32'h0000A5C3);
        check("restart_n",   32'(wr_idx.size()), 32'(NW + CHK));

        // Checksum pattern: 1234, 00FF, then zeros
        for (int i = 0; i < NW; i++) wv[i] = 16'h0000;
        wv[0] = 16'h1234;
        wv[1] = 16'h00FF;
        add_capture(-1, 0, -1, -1, 0);
        play();
        check("chk_nwrites", 32'(wr_idx.size()), 32'(NW + CHK));
        check("chk_done",    32'(done_idx[0] - k_edge), 32'(323 + CHK));
`ifdef BKY_CHKSUM_EN
        check("chk_word",    32'(wr_val[19]), 32'h000012CB);
        check("chk_edge",    32'(wr_idx[19] - k_edge), 32'd323);
`else
        check("last_word",   32'(wr_val[18]), 32'h00000000);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
